// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared encodings, default timing constants and BCD helper for the pedestrian crossing controller.
package ped_pkg;

  typedef logic [1:0] ped_state_t;

  localparam ped_state_t ST_DW   = 2'b00;
  localparam ped_state_t ST_WALK = 2'b01;
  localparam ped_state_t ST_CLR  = 2'b10;

  localparam logic [4:0] GREEN_TIME_DEF = 5'd30;
  localparam logic [4:0] CLEAR_TIME_DEF = 5'd8;
  localparam logic [3:0] FLASH_DIV_DEF  = 4'd2;

  // Two-digit BCD of a 5-bit value (0..31)
  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [3:0] tens;
    logic [4:0] units;
    if (v >= 5'd30) begin
      tens  = 4'd3;
      units = v - 5'd30;
    end else if (v >= 5'd20) begin
      tens  = 4'd2;
      units = v - 5'd20;
    end else if (v >= 5'd10) begin
      tens  = 4'd1;
      units = v - 5'd10;
    end else begin
      tens  = 4'd0;
      units = v;
    end
    return {tens, units[3:0]};
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_head_fsm.sv
// One crosswalk head: request latch, DW/WALK/CLR state machine, flash timing and countdown register.
// Countdown format follows PED_COUNT_BCD_EN (BCD when defined, binary otherwise).
module ped_head_fsm
  import ped_pkg::*;
#(
  parameter logic [4:0] GREEN_TIME = GREEN_TIME_DEF,
  parameter logic [4:0] CLEAR_TIME = CLEAR_TIME_DEF,
  parameter logic [3:0] FLASH_DIV  = FLASH_DIV_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       green_i,
  input  logic       req_i,
  input  logic       fault_i,
  input  logic [4:0] timer_i,
  output logic       walk_o,
  output logic       dont_walk_o,
  output logic       pending_o,
  output logic [7:0] count_o,
  output logic       walk_state_o
);

  localparam logic [4:0] CLR_START = GREEN_TIME - CLEAR_TIME;

  ped_state_t state_q, state_d;
  logic       green_q;
  logic       pend_q, pend_d;
  logic [3:0] flash_cnt_q, flash_cnt_d;
  logic       flash_ph_q, flash_ph_d;
  logic       walk_d, dont_walk_d;
  logic [7:0] count_d;
  logic       green_start_s, grant_s;
  logic [4:0] cnt5_s;
  logic [7:0] cnt8_s;

  // Next state, request latch and flash timing
  always_comb begin
    green_start_s = green_i & ~green_q;
    grant_s       = green_start_s & (pend_q | req_i) & ~fault_i & (state_q == ST_DW);
    state_d       = state_q;
    if (fault_i || !green_i) begin
      state_d = ST_DW;
    end else begin
      case (state_q)
        ST_DW:   state_d = grant_s ? ST_WALK : ST_DW;
        ST_WALK: state_d = (timer_i >= CLR_START) ? ST_CLR : ST_WALK;
        ST_CLR:  state_d = ST_CLR;
        default: state_d = ST_DW;
      endcase
    end
    pend_d = grant_s ? 1'b0 : (pend_q | req_i);

    // Phase is loaded high on CLR entry, then toggles every FLASH_DIV cycles
    if ((state_d == ST_CLR) && (state_q != ST_CLR)) begin
      flash_cnt_d = 4'd0;
      flash_ph_d  = 1'b1;
    end else if (state_d == ST_CLR) begin
      if (flash_cnt_q == (FLASH_DIV - 4'd1)) begin
        flash_cnt_d = 4'd0;
        flash_ph_d  = ~flash_ph_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 4'd1;
        flash_ph_d  = flash_ph_q;
      end
    end else begin
      flash_cnt_d = 4'd0;
      flash_ph_d  = 1'b0;
    end
  end

  // Head outputs from the current state and timer sample
  always_comb begin
    cnt5_s = (timer_i > GREEN_TIME) ? 5'd0 : (GREEN_TIME - timer_i);
`ifdef PED_COUNT_BCD_EN
    cnt8_s = to_bcd(cnt5_s);
`else
    cnt8_s = {3'b000, cnt5_s};
`endif
    walk_d      = 1'b0;
    dont_walk_d = 1'b1;
    count_d     = 8'd0;
    if (fault_i) begin
      walk_d      = 1'b0;
      dont_walk_d = 1'b1;
      count_d     = 8'd0;
    end else begin
      case (state_q)
        ST_WALK: begin
          walk_d      = 1'b1;
          dont_walk_d = 1'b0;
          count_d     = cnt8_s;
        end
        ST_CLR: begin
          walk_d      = 1'b0;
          dont_walk_d = flash_ph_q;
          count_d     = cnt8_s;
        end
        default: begin
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          count_d     = 8'd0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_DW;
      green_q     <= 1'b0;
      pend_q      <= 1'b0;
      flash_cnt_q <= 4'd0;
      flash_ph_q  <= 1'b0;
      walk_o      <= 1'b0;
      dont_walk_o <= 1'b1;
      count_o     <= 8'd0;
    end else begin
      state_q     <= state_d;
      green_q     <= green_i;
      pend_q      <= pend_d;
      flash_cnt_q <= flash_cnt_d;
      flash_ph_q  <= flash_ph_d;
      walk_o      <= walk_d;
      dont_walk_o <= dont_walk_d;
      count_o     <= count_d;
    end
  end

  assign pending_o    = pend_q;
  assign walk_state_o = (state_q == ST_WALK);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: two crosswalk heads fed by the upstream lamps plus a sticky fault detector.
// Define PED_COUNT_BCD_EN to present the countdowns as two BCD digits.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter logic [4:0] GREEN_TIME = GREEN_TIME_DEF,
  parameter logic [4:0] CLEAR_TIME = CLEAR_TIME_DEF,
  parameter logic [3:0] FLASH_DIV  = FLASH_DIV_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       NS_RED,
  input  logic       NS_YELLOW,
  input  logic       NS_GREEN,
  input  logic       EW_RED,
  input  logic       EW_YELLOW,
  input  logic       EW_GREEN,
  input  logic [4:0] timer,
  input  logic       NS_PED_REQ,
  input  logic       EW_PED_REQ,
  output logic       NS_WALK,
  output logic       NS_DONT_WALK,
  output logic       EW_WALK,
  output logic       EW_DONT_WALK,
  output logic       NS_REQ_PENDING,
  output logic       EW_REQ_PENDING,
  output logic [7:0] NS_COUNT,
  output logic [7:0] EW_COUNT,
  output logic       FAULT
);

  logic fault_d;
  logic ns_walk_st_s, ew_walk_st_s;
  logic ns_go_s, ew_go_s;

  // Conflicts: both green, both showing a go lamp with no red anywhere, or both heads walking
  always_comb begin
    ns_go_s = NS_GREEN | NS_YELLOW;
    ew_go_s = EW_GREEN | EW_YELLOW;
    fault_d = FAULT
            | (NS_GREEN & EW_GREEN)
            | (ns_go_s & ew_go_s & ~NS_RED & ~EW_RED)
            | (ns_walk_st_s & ew_walk_st_s);
  end

  // Sticky fault register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FAULT <= 1'b0;
    end else begin
      FAULT <= fault_d;
    end
  end

  ped_head_fsm #(
    .GREEN_TIME(GREEN_TIME), .CLEAR_TIME(CLEAR_TIME), .FLASH_DIV(FLASH_DIV)
  ) u_ns (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .green_i     (NS_GREEN),
    .req_i       (NS_PED_REQ),
    .fault_i     (fault_d),
    .timer_i     (timer),
    .walk_o      (NS_WALK),
    .dont_walk_o (NS_DONT_WALK),
    .pending_o   (NS_REQ_PENDING),
    .count_o     (NS_COUNT),
    .walk_state_o(ns_walk_st_s)
  );

  ped_head_fsm #(
    .GREEN_TIME(GREEN_TIME), .CLEAR_TIME(CLEAR_TIME), .FLASH_DIV(FLASH_DIV)
  ) u_ew (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .green_i     (EW_GREEN),
    .req_i       (EW_PED_REQ),
    .fault_i     (fault_d),
    .timer_i     (timer),
    .walk_o      (EW_WALK),
    .dont_walk_o (EW_DONT_WALK),
    .pending_o   (EW_REQ_PENDING),
    .count_o     (EW_COUNT),
    .walk_state_o(ew_walk_st_s)
  );

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with hand-computed expectations (default timing 30/8/2).
module tb_ped_crossing_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       NS_RED, NS_YELLOW, NS_GREEN;
  logic       EW_RED, EW_YELLOW, EW_GREEN;
  logic [4:0] timer;
  logic       NS_PED_REQ, EW_PED_REQ;
  logic       NS_WALK, NS_DONT_WALK, EW_WALK, EW_DONT_WALK;
  logic       NS_REQ_PENDING, EW_REQ_PENDING;
  logic [7:0] NS_COUNT, EW_COUNT;
  logic       FAULT;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  int tests = 0;
  int fails = 0;

  ped_crossing_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .NS_RED(NS_RED), .NS_YELLOW(NS_YELLOW), .NS_GREEN(NS_GREEN),
    .EW_RED(EW_RED), .EW_YELLOW(EW_YELLOW), .EW_GREEN(EW_GREEN),
    .timer(timer), .NS_PED_REQ(NS_PED_REQ), .EW_PED_REQ(EW_PED_REQ),
    .NS_WALK(NS_WALK), .NS_DONT_WALK(NS_DONT_WALK),
    .EW_WALK(EW_WALK), .EW_DONT_WALK(EW_DONT_WALK),
    .NS_REQ_PENDING(NS_REQ_PENDING), .EW_REQ_PENDING(EW_REQ_PENDING),
    .NS_COUNT(NS_COUNT), .EW_COUNT(EW_COUNT), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ecnt(input int v);
    logic [7:0] r;
`ifdef PED_COUNT_BCD_EN
    logic [3:0] tn, un;
    tn = 4'(v / 10);
    un = 4'(v % 10);
    r  = {tn, un};
`else
    r = 8'(v);
`endif
    return r;
  endfunction

  task automatic lamps(input logic [2:0] ns, input logic [2:0] ew);
    {NS_RED, NS_YELLOW, NS_GREEN} = ns;
    {EW_RED, EW_YELLOW, EW_GREEN} = ew;
  endtask

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic       e_dw;
    logic [7:0] e23;
`ifdef PED_COUNT_BCD_EN
    e23 = 8'h23;
`else
    e23 = 8'd23;
`endif
    RESET = 1'b1;
    lamps(L_G, L_R);
    timer = 5'd0;
    NS_PED_REQ = 1'b1;
    EW_PED_REQ = 1'b0;
    #12;
    chk1("rst_ns_walk", NS_WALK, 1'b0);
    chk1("rst_ns_dw", NS_DONT_WALK, 1'b1);
    chk1("rst_ew_dw", EW_DONT_WALK, 1'b1);
    chk1("rst_pend", NS_REQ_PENDING, 1'b0);
    chk8("rst_ns_cnt", NS_COUNT, 8'd0);
    chk1("rst_fault", FAULT, 1'b0);
    RESET = 1'b0;

    // First sampled green after reset with the button held: grant consumes the request
    clk1();
    chk1("grant_walk_lat", NS_WALK, 1'b0);
    chk1("grant_pend", NS_REQ_PENDING, 1'b0);
    NS_PED_REQ = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      timer = 5'(t);
      clk1();
      e_dw = (t <= 22) ? 1'b0 : ((((t - 23) / 2) % 2) == 0);
      chk1("ph1_walk", NS_WALK, (t <= 22));
      chk1("ph1_dw", NS_DONT_WALK, e_dw);
      chk8("ph1_cnt", NS_COUNT, ecnt(30 - t));
      if (t == 1) begin
        chk1("ph1_ew_dw", EW_DONT_WALK, 1'b1);
        chk1("ph1_ew_walk", EW_WALK, 1'b0);
      end
      if (t == 7) chk8("cnt_t7", NS_COUNT, e23);
    end

    lamps(L_Y, L_R);
    timer = 5'd0;
    clk1();
    timer = 5'd1;
    clk1();
    chk1("yel_dw", NS_DONT_WALK, 1'b1);
    chk1("yel_walk", NS_WALK, 1'b0);
    chk8("yel_cnt", NS_COUNT, 8'd0);

    // EW green without any request stays DONT_WALK
    lamps(L_R, L_G);
    for (int t = 0; t <= 5; t++) begin
      timer = 5'(t);
      clk1();
      chk1("ew_norq_dw", EW_DONT_WALK, 1'b1);
      chk8("ew_norq_cnt", EW_COUNT, 8'd0);
    end
    chk1("no_fault", FAULT, 1'b0);
    lamps(L_R, L_Y);
    timer = 5'd0;
    clk1();

    // NS green with no request; mid-green request becomes pending
    lamps(L_G, L_R);
    for (int t = 0; t <= 30; t++) begin
      timer = 5'(t);
      NS_PED_REQ = (t == 10);
      clk1();
      chk1("norq_dw", NS_DONT_WALK, 1'b1);
      chk8("norq_cnt", NS_COUNT, 8'd0);
      chk1("norq_pend", NS_REQ_PENDING, (t >= 10));
    end
    NS_PED_REQ = 1'b0;
    lamps(L_Y, L_R);
    timer = 5'd0;
    clk1();
    lamps(L_R, L_G);
    for (int t = 0; t <= 3; t++) begin
      timer = 5'(t);
      clk1();
    end
    chk1("pend_held", NS_REQ_PENDING, 1'b1);

    lamps(L_G, L_R);
    timer = 5'd0;
    clk1();
    chk1("pend_clr", NS_REQ_PENDING, 1'b0);
    timer = 5'd1;
    clk1();
    chk1("ph2_walk", NS_WALK, 1'b1);
    chk8("ph2_cnt", NS_COUNT, ecnt(29));

    // Conflicting greens for one cycle
    lamps(L_G, L_G);
    timer = 5'd2;
    clk1();
    chk1("flt_set", FAULT, 1'b1);
    chk1("flt_ns_walk", NS_WALK, 1'b0);
    chk1("flt_ns_dw", NS_DONT_WALK, 1'b1);
    chk8("flt_ns_cnt", NS_COUNT, 8'd0);
    lamps(L_G, L_R);
    timer = 5'd3;
    EW_PED_REQ = 1'b1;
    clk1();
    EW_PED_REQ = 1'b0;
    chk1("flt_sticky", FAULT, 1'b1);
    chk1("flt_ns_dw2", NS_DONT_WALK, 1'b1);
    chk8("flt_ns_cnt2", NS_COUNT, 8'd0);
    chk1("flt_ew_pend", EW_REQ_PENDING, 1'b1);
    chk1("flt_ew_dw", EW_DONT_WALK, 1'b1);
    timer = 5'd4;
    clk1();
    chk1("flt_sticky2", FAULT, 1'b1);

    RESET = 1'b1;
    #1;
    chk1("rst2_fault", FAULT, 1'b0);
    chk1("rst2_ew_pend", EW_REQ_PENDING, 1'b0);
    chk1("rst2_ns_dw", NS_DONT_WALK, 1'b1);
    timer = 5'd0;
    NS_PED_REQ = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    clk1();
    NS_PED_REQ = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      timer = 5'(t);
      clk1();
    end
    chk1("pre_rst_walk", NS_WALK, 1'b1);
    chk8("pre_rst_cnt", NS_COUNT, ecnt(15));

    // Asynchronous reset mid-WALK, then no re-grant without a new request
    RESET = 1'b1;
    #1;
    chk1("arst_walk", NS_WALK, 1'b0);
    chk1("arst_dw", NS_DONT_WALK, 1'b1);
    chk8("arst_cnt", NS_COUNT, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int t = 16; t <= 20; t++) begin
      timer = 5'(t);
      clk1();
      chk1("post_rst_walk", NS_WALK, 1'b0);
      chk1("post_rst_dw", NS_DONT_WALK, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
